stopwatch_ctrl_99sec: RTL and testbench
=======================================

# stopwatch_ctrl_99sec

Stopwatch controller that sequences the 0–99 s seconds count shown on the two-digit 7-segment display. It turns three debounced push-buttons (start/stop, lap, clear) into run, pause, lap-freeze and clear behaviour, and prescales the board clock into 1 s ticks. Its 7-bit binary display value feeds the existing `bcd_2digit` converter directly, and its `indicator` output drives the clock-pulse LED.

## Interface
- `CLK_DIV`, default 50000000: clkIn cycles per second (≥2; benches use 4).
- `WRAP`, default 0: 1 = 99→0 and keep running; 0 = stop at 99 in DONE.
- `clkIn  in  1`: system clock; all logic is on the rising edge.
- `rst  in  1`: synchronous, active-low reset.
- `btnStart  in  1`: start/stop toggle; level input, debounced upstream, synchronous to clkIn.
- `btnLap  in  1`: lap freeze/release; level input, debounced.
- `btnClear  in  1`: clear to zero; level input, debounced.
- `dispNum  out  7`: value to display, 0..99 binary; goes to the converter's `binaryNum`.
- `indicator  out  1`: seconds blink for the LED.
- `running  out  1`: high in RUN or LAP.
- `lapActive  out  1`: high in LAP.
- `done  out  1`: high in DONE.

## Operation
- Edge detect: one `prev` register per button, with `edge = btn & ~prev`. Reset loads every `prev` with 1, so a button held through reset does not fire.
- Same-cycle button priority: clear > start > lap. Only the highest-priority edge acts; the others are dropped.
- Internal registers:
  - `sec`: 7 bits, 0..99.
  - `pre`: 0..CLK_DIV-1, counts only in RUN and LAP.
  - `lapVal`: 7 bits.
- `tick = (pre == CLK_DIV-1)` while in RUN or LAP. On a tick, `pre` goes to 0 and `sec` increments, subject to the max rule below.
- State IDLE (`sec`=0, `pre`=0):
  - start → RUN.
  - lap is ignored.
- State RUN:
  - start → PAUSE.
  - lap → LAP, and `lapVal` takes the current (pre-increment) `sec`.
  - tick with `sec`=99: if WRAP=1, `sec`→0 and stay in RUN; if WRAP=0, `sec` holds 99 and go to DONE.
- State LAP: counting continues exactly as in RUN.
  - lap → RUN (display goes live again).
  - start → PAUSE (display goes live).
  - Max-count tick: same rule as RUN, and lap is released.
- State PAUSE: `sec` and `pre` hold; the partial second is preserved.
  - start → RUN.
  - lap is ignored.
- State DONE: `sec` = 99.
  - start and lap are ignored.
- Clear edge in any state: go to IDLE, with `sec`=0, `pre`=0, `lapVal`=0.
- A tick and a button edge in the same cycle both take effect. For example, RUN + tick + start: `sec` increments and the next state is PAUSE.
- `dispNum` is `lapVal` in LAP, and `sec` in every other state.
- `indicator` is 1 when in RUN or LAP and `pre < CLK_DIV/2` (integer division); otherwise 0.

## Timing
- All outputs are registered, or decoded only from registered state.
- Reset values: state IDLE; `sec`, `pre`, `lapVal` = 0; `dispNum` = 0; `indicator`, `running`, `lapActive`, `done` = 0.
- Reset takes priority over every other input, including a reset asserted mid-count or in LAP.
- Button latency: the first edge that samples btn=1 (with prev=0) updates the state. The new outputs are visible after that edge, i.e. one cycle.
- From entering RUN with `pre`=0, the first increment of `sec` happens CLK_DIV cycles later. After that, increments come every CLK_DIV cycles.
- PAUSE→RUN resumes `pre` from its held value, so the remaining time to the next tick is CLK_DIV-1-`pre`+1 cycles.
- A held button produces exactly one action. The button must go low for at least one cycle before it can fire again.

## Test plan
All scenarios use CLK_DIV=4.
- Reset, then start pulse → `running`=1 on the next cycle; `dispNum` reads 1, 2, 3 at cycles 4, 8, 12 after entry; `indicator` pattern is 1,1,0,0 per second.
- At `dispNum`=5, press start, wait 20 cycles, press start again → `dispNum` stays 5 throughout PAUSE. It reaches 6 after the remaining prescale cycles (≤4), not after 4 full cycles.
- RUN at `sec`=7, press lap → `dispNum` stays 7 and `lapActive`=1 while `sec` advances. After 3 ticks, press lap → `dispNum`=10 and `lapActive`=0.
- WRAP=0, run to 99 → `done`=1, `running`=0, `dispNum`=99; start is ignored. Press clear → `dispNum`=0 in IDLE.
- WRAP=1 → 99 is followed by 0 on the next tick, `running` stays 1, `done` stays 0.
- Start and clear asserted together while in RUN → IDLE with `dispNum`=0. Separately: button held high through reset release → no state change. Separately: `rst`=0 asserted while in LAP → all outputs 0 on the next edge.

Source files
------------

// File: rtl/stopwatch_ctrl_99sec.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_99sec
// Two-digit (0..99 s) stopwatch sequencer. Three debounced push-buttons give
// run/pause, lap-freeze and clear. The board clock is prescaled into 1 s ticks.
//
// Parameters
//   CLK_DIV : clkIn cycles per second (>= 2)
//   WRAP    : 1 = 99 -> 0 and keep running, 0 = stop at 99 in DONE
// Ports
//   clkIn      in  system clock, rising edge
//   rst        in  synchronous active-low reset
//   btnStart   in  start/stop toggle (level, debounced)
//   btnLap     in  lap freeze/release (level, debounced)
//   btnClear   in  clear to zero (level, debounced)
//   dispNum    out display value 0..99 (lap value while in LAP)
//   indicator  out seconds blink, high for the first half of each second
//   running    out high in RUN or LAP
//   lapActive  out high in LAP
//   done       out high in DONE
// -----------------------------------------------------------------------------
module stopwatch_ctrl_99sec #(
  parameter int unsigned CLK_DIV = 50000000,
  parameter bit          WRAP    = 1'b0
) (
  input  logic       clkIn,
  input  logic       rst,
  input  logic       btnStart,
  input  logic       btnLap,
  input  logic       btnClear,
  output logic [6:0] dispNum,
  output logic       indicator,
  output logic       running,
  output logic       lapActive,
  output logic       done
);

  localparam int unsigned PRE_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_DIV / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_LAP,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [6:0]       r_sec;
  logic [6:0]       r_lapVal;
  logic [PRE_W-1:0] r_pre;
  logic             r_prevStart;
  logic             r_prevLap;
  logic             r_prevClear;

  logic w_clrE;
  logic w_startE;
  logic w_lapE;
  logic w_counting;
  logic w_tick;
  logic w_maxTick;

  // Only the highest-priority edge acts: clear > start > lap.
  assign w_clrE   = btnClear & ~r_prevClear;
  assign w_startE = btnStart & ~r_prevStart & ~w_clrE;
  assign w_lapE   = btnLap & ~r_prevLap & ~w_clrE & ~w_startE;

  assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_tick     = w_counting && (r_pre == PRE_MAX);
  assign w_maxTick  = w_tick && (r_sec == 7'd99);

  // Previous-level registers reset to 1 so a button held through reset is quiet.
  always_ff @(posedge clkIn) begin
    if (!rst) begin
      r_prevStart <= 1'b1;
      r_prevLap   <= 1'b1;
      r_prevClear <= 1'b1;
    end else begin
      r_prevStart <= btnStart;
      r_prevLap   <= btnLap;
      r_prevClear <= btnClear;
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_clrE) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_startE) w_next = S_RUN;
        S_RUN: begin
          if (w_maxTick && !WRAP) w_next = S_DONE;
          else if (w_startE)      w_next = S_PAUSE;
          else if (w_lapE)        w_next = S_LAP;
        end
        S_LAP: begin
          // A wrapping max-count tick also releases the lap freeze.
          if (w_maxTick && !WRAP)       w_next = S_DONE;
          else if (w_startE)            w_next = S_PAUSE;
          else if (w_lapE || w_maxTick) w_next = S_RUN;
        end
        S_PAUSE: if (w_startE) w_next = S_RUN;
        S_DONE:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rst || w_clrE) begin
      r_sec    <= '0;
      r_pre    <= '0;
      r_lapVal <= '0;
    end else begin
      if (w_counting) begin
        if (w_tick) r_pre <= '0;
        else        r_pre <= r_pre + 1'b1;
      end
      if (w_tick) begin
        if (r_sec == 7'd99) r_sec <= WRAP ? 7'd0 : 7'd99;
        else                r_sec <= r_sec + 7'd1;
      end
      // Captures the pre-increment value even when a tick lands on the same edge.
      if ((r_state == S_RUN) && w_lapE) r_lapVal <= r_sec;
    end
  end

  always_comb begin
    dispNum   = (r_state == S_LAP) ? r_lapVal : r_sec;
    indicator = w_counting && (r_pre < PRE_HALF);
    running   = w_counting;
    lapActive = (r_state == S_LAP);
    done      = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_stopwatch_ctrl_99sec.sv
module tb_stopwatch_ctrl_99sec;

  localparam int DIV = 4;
  localparam int MD_IDLE = 0, MD_RUN = 1, MD_LAP = 2, MD_PAUSE = 3, MD_DONE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bS = 1'b0, bL = 1'b0, bC = 1'b0;

  logic [6:0] d0, d1;
  logic i0, r0, l0, dn0, i1, r1, l1, dn1;
  logic [21:0] obs;
  assign obs = {d0, i0, r0, l0, dn0, d1, i1, r1, l1, dn1};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per instance (0: no wrap, 1: wrap), a mode, the total
  // number of counted cycles, and the captured lap value.
  int m_mode[2];
  int m_el[2];
  int m_lv[2];
  bit p_s = 1'b1, p_l = 1'b1, p_c = 1'b1;

  stopwatch_ctrl_99sec #(.CLK_DIV(DIV), .WRAP(1'b0)) u_dut0 (
    .clkIn(clk), .rst(rst), .btnStart(bS), .btnLap(bL), .btnClear(bC),
    .dispNum(d0), .indicator(i0), .running(r0), .lapActive(l0), .done(dn0)
  );

  stopwatch_ctrl_99sec #(.CLK_DIV(DIV), .WRAP(1'b1)) u_dut1 (
    .clkIn(clk), .rst(rst), .btnStart(bS), .btnLap(bL), .btnClear(bC),
    .dispNum(d1), .indicator(i1), .running(r1), .lapActive(l1), .done(dn1)
  );

  always #5 clk = ~clk;

  function automatic int m_sec(int w);
    int s;
    s = m_el[w] / DIV;
    if (w == 1) return s % 100;
    return (s > 99) ? 99 : s;
  endfunction

  function automatic logic [21:0] m_exp();
    logic [10:0] part [2];
    for (int w = 0; w < 2; w++) begin
      int disp;
      bit cnt;
      cnt  = (m_mode[w] == MD_RUN) || (m_mode[w] == MD_LAP);
      disp = (m_mode[w] == MD_LAP) ? m_lv[w] : m_sec(w);
      part[w] = {7'(disp), cnt && ((m_el[w] % DIV) < DIV / 2), cnt,
                 m_mode[w] == MD_LAP, m_mode[w] == MD_DONE};
    end
    return {part[0], part[1]};
  endfunction

  function automatic void m_step();
    bit es, el, ec;
    if (!rst) begin
      for (int w = 0; w < 2; w++) begin
        m_mode[w] = MD_IDLE; m_el[w] = 0; m_lv[w] = 0;
      end
      p_s = 1'b1; p_l = 1'b1; p_c = 1'b1;
      return;
    end
    ec = bC && !p_c;
    es = bS && !p_s && !ec;
    el = bL && !p_l && !ec && !es;
    p_s = bS; p_l = bL; p_c = bC;
    for (int w = 0; w < 2; w++) begin
      bit cnt, maxt;
      int s0;
      if (ec) begin
        m_mode[w] = MD_IDLE; m_el[w] = 0; m_lv[w] = 0;
        continue;
      end
      cnt  = (m_mode[w] == MD_RUN) || (m_mode[w] == MD_LAP);
      s0   = m_sec(w);
      maxt = cnt && ((m_el[w] % DIV) == DIV - 1) && (s0 == 99);
      if (cnt) m_el[w]++;
      case (m_mode[w])
        MD_IDLE:  if (es) m_mode[w] = MD_RUN;
        MD_RUN: begin
          if (maxt && w == 0) m_mode[w] = MD_DONE;
          else if (es)        m_mode[w] = MD_PAUSE;
          else if (el) begin  m_mode[w] = MD_LAP; m_lv[w] = s0; end
        end
        MD_LAP: begin
          if (maxt && w == 0)  m_mode[w] = MD_DONE;
          else if (es)         m_mode[w] = MD_PAUSE;
          else if (el || maxt) m_mode[w] = MD_RUN;
        end
        MD_PAUSE: if (es) m_mode[w] = MD_RUN;
        default: ;
      endcase
    end
  endfunction

  task automatic step();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bS = 1'b1; bL = 1'b1; bC = 1'b1; rst = 1'b0;
    step(); step();
    n_checks++;
    if (obs !== 22'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%h want=%h", obs, 22'd0);
    end
    bS = 1'b0; bL = 1'b0; bC = 1'b0;
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if (obs !== m_exp()) begin
      n_fail++; $display("FAIL reset_release got=%h want=%h", obs, m_exp());
    end
  endtask

  task automatic test_run();
    bS = 1'b1; step(); bS = 1'b0;
    n_checks++;
    if (r0 !== 1'b1 || i0 !== 1'b1 || d0 !== 7'd0) begin
      n_fail++; $display("FAIL run_entry got run=%b ind=%b disp=%0d want 1 1 0", r0, i0, d0);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      n_checks++;
      if (i0 !== ((k % 4) < 2)) begin
        n_fail++; $display("FAIL run_indicator k=%0d got=%b want=%b", k, i0, (k % 4) < 2);
      end
      if (k % 4 == 0) begin
        n_checks++;
        if (d0 !== 7'(k / 4)) begin
          n_fail++; $display("FAIL run_count k=%0d got=%0d want=%0d", k, d0, k / 4);
        end
      end
      n_checks++;
      if (obs !== m_exp()) begin
        n_fail++; $display("FAIL run_model k=%0d got=%h want=%h", k, obs, m_exp());
      end
    end
  endtask

  task automatic test_pause();
    int n;
    n = 0;
    while (!(m_sec(0) == 5 && (m_el[0] % DIV) == 1) && n < 200) begin
      step(); n++;
    end
    n_checks++;
    if (n >= 200) begin
      n_fail++; $display("FAIL pause_setup got timeout want sec=5");
    end
    bS = 1'b1; step(); bS = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      n_checks++;
      if (d0 !== 7'd5 || r0 !== 1'b0 || obs !== m_exp()) begin
        n_fail++; $display("FAIL pause_hold k=%0d got disp=%0d run=%b want disp=5 run=0", k, d0, r0);
      end
    end
    bS = 1'b1; step(); bS = 1'b0;
    n = 0;
    while (d0 !== 7'd6 && n < 8) begin
      step(); n++;
    end
    n_checks++;
    if (n != 2) begin
      n_fail++; $display("FAIL pause_resume_latency got=%0d want=2", n);
    end
  endtask

  task automatic test_lap();
    int n;
    bC = 1'b1; step(); bC = 1'b0;
    bS = 1'b1; step(); bS = 1'b0;
    n = 0;
    while (m_el[0] != 29 && n < 200) begin
      step(); n++;
    end
    bL = 1'b1; step(); bL = 1'b0;
    n_checks++;
    if (l0 !== 1'b1 || d0 !== 7'd7 || r0 !== 1'b1) begin
      n_fail++; $display("FAIL lap_enter got lap=%b disp=%0d run=%b want 1 7 1", l0, d0, r0);
    end
    n = 0;
    while (m_sec(0) < 10 && n < 40) begin
      step(); n++;
      n_checks++;
      if (d0 !== 7'd7 || l0 !== 1'b1 || obs !== m_exp()) begin
        n_fail++; $display("FAIL lap_frozen got disp=%0d lap=%b want disp=7 lap=1", d0, l0);
      end
    end
    bL = 1'b1; step(); bL = 1'b0;
    n_checks++;
    if (d0 !== 7'd10 || l0 !== 1'b0 || r0 !== 1'b1) begin
      n_fail++; $display("FAIL lap_release got disp=%0d lap=%b run=%b want 10 0 1", d0, l0, r0);
    end
  endtask

  task automatic test_max();
    bC = 1'b1; step(); bC = 1'b0;
    bS = 1'b1; step(); bS = 1'b0;
    for (int k = 1; k < 400; k++) begin
      step();
      n_checks++;
      if (obs !== m_exp()) begin
        n_fail++; $display("FAIL max_model k=%0d got=%h want=%h", k, obs, m_exp());
      end
    end
    n_checks++;
    if (d0 !== 7'd99 || d1 !== 7'd99 || dn0 !== 1'b0) begin
      n_fail++; $display("FAIL max_at99 got d0=%0d d1=%0d done=%b want 99 99 0", d0, d1, dn0);
    end
    step();
    n_checks++;
    if (dn0 !== 1'b1 || r0 !== 1'b0 || d0 !== 7'd99) begin
      n_fail++; $display("FAIL max_done got done=%b run=%b disp=%0d want 1 0 99", dn0, r0, d0);
    end
    n_checks++;
    if (d1 !== 7'd0 || r1 !== 1'b1 || dn1 !== 1'b0) begin
      n_fail++; $display("FAIL max_wrap got disp=%0d run=%b done=%b want 0 1 0", d1, r1, dn1);
    end
    bS = 1'b1; step(); bS = 1'b0; step();
    n_checks++;
    if (dn0 !== 1'b1 || d0 !== 7'd99 || r0 !== 1'b0) begin
      n_fail++; $display("FAIL done_ignores_start got done=%b disp=%0d want 1 99", dn0, d0);
    end
    bC = 1'b1; step(); bC = 1'b0;
    n_checks++;
    if (d0 !== 7'd0 || dn0 !== 1'b0 || r0 !== 1'b0 || obs !== m_exp()) begin
      n_fail++; $display("FAIL done_clear got disp=%0d done=%b want 0 0", d0, dn0);
    end
  endtask

  task automatic test_clear_priority();
    bS = 1'b1; step(); bS = 1'b0;
    repeat (5) step();
    bS = 1'b1; bC = 1'b1; step(); bS = 1'b0; bC = 1'b0;
    n_checks++;
    if (d0 !== 7'd0 || r0 !== 1'b0 || i0 !== 1'b0) begin
      n_fail++; $display("FAIL clear_priority got disp=%0d run=%b want 0 0", d0, r0);
    end
  endtask

  task automatic test_hold_reset();
    bS = 1'b1; rst = 1'b0; step();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (r0 !== 1'b0 || d0 !== 7'd0 || obs !== m_exp()) begin
        n_fail++; $display("FAIL held_through_reset k=%0d got run=%b want 0", k, r0);
      end
    end
    bS = 1'b0; step();
  endtask

  task automatic test_reset_in_lap();
    bS = 1'b1; step(); bS = 1'b0;
    repeat (6) step();
    bL = 1'b1; step(); bL = 1'b0;
    n_checks++;
    if (l0 !== 1'b1) begin
      n_fail++; $display("FAIL lap_before_reset got=%b want=1", l0);
    end
    step();
    rst = 1'b0; step();
    n_checks++;
    if (obs !== 22'd0) begin
      n_fail++; $display("FAIL reset_in_lap got=%h want=%h", obs, 22'd0);
    end
    rst = 1'b1; step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 4000; k++) begin
      bS  = ($urandom_range(0, 9) == 0);
      bL  = ($urandom_range(0, 7) == 0);
      bC  = ($urandom_range(0, 149) == 0);
      rst = ($urandom_range(0, 499) != 0);
      step();
      n_checks++;
      if (obs !== m_exp()) begin
        n_fail++; $display("FAIL random_model k=%0d got=%h want=%h", k, obs, m_exp());
      end
    end
    bS = 1'b0; bL = 1'b0; bC = 1'b0; rst = 1'b1;
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      m_mode[w] = MD_IDLE; m_el[w] = 0; m_lv[w] = 0;
    end
    @(negedge clk);
    test_reset();
    test_run();
    test_pause();
    test_lap();
    test_max();
    test_clear_priority();
    test_hold_reset();
    test_reset_in_lap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
